// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the pipeline register chain
//
// Purpose: stage entry layout at the default widths, the all-zero entry, the
// stage-index width helper and a 16-bit saturating adder for the optional
// performance counters (PIPE_STAGE_PERF_EN).
// Ports: none (package).

package pipe_pkg;

   localparam int PIPE_DATA_W     = 64;
   localparam int PIPE_REG_ADDR_W = 5;

   typedef struct packed {
      logic                       valid;
      logic                       wen;
      logic [PIPE_REG_ADDR_W-1:0] wreg;
      logic [PIPE_DATA_W-1:0]     data;
   } stage_entry_t;

   localparam stage_entry_t STAGE_ENTRY_ZERO = '0;

   // Width of a stage index; a single-stage chain still gets a 1-bit index.
   function automatic int stage_idx_w(input int stages);
      return (stages > 1) ? $clog2(stages) : 1;
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/pipe_fwd_lookup.sv
// rtl/pipe_fwd_lookup.sv - priority forwarding search for one source register
//
// Purpose: combinational search over stages FWD_FIRST..STAGES-1; a stage
// matches when valid && wen && wreg==src && src!=0. The youngest (lowest
// index) match wins; no match gives hit=0, stage=0, data=0.
// Ports:
//   stage_valid, stage_wen  in   per-stage valid / write-enable
//   stage_wreg, stage_data  in   per-stage destination register / payload
//   src                     in   register being looked up
//   hit, hit_stage, hit_data out  match flag, matching stage index, its payload

module pipe_fwd_lookup
   import pipe_pkg::*;
#(
   parameter int STAGES     = 4,
   parameter int DATA_W     = PIPE_DATA_W,
   parameter int REG_ADDR_W = PIPE_REG_ADDR_W,
   parameter int FWD_FIRST  = 1,
   localparam int IDX_W     = stage_idx_w(STAGES)
)(
   input  logic [STAGES-1:0]                 stage_valid,
   input  logic [STAGES-1:0]                 stage_wen,
   input  logic [STAGES-1:0][REG_ADDR_W-1:0] stage_wreg,
   input  logic [STAGES-1:0][DATA_W-1:0]     stage_data,
   input  logic [REG_ADDR_W-1:0]             src,
   output logic                              hit,
   output logic [IDX_W-1:0]                  hit_stage,
   output logic [DATA_W-1:0]                 hit_data
);

   // Walk from oldest to youngest so the youngest match is the last writer.
   always_comb begin
      hit       = 1'b0;
      hit_stage = '0;
      hit_data  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (k >= FWD_FIRST && stage_valid[k] && stage_wen[k] &&
             stage_wreg[k] == src && src != '0) begin
            hit       = 1'b1;
            hit_stage = IDX_W'(k);
            hit_data  = stage_data[k];
         end
      end
   end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - parametrised pipeline register chain with stall, flush and forwarding
//
// Purpose: STAGES pipeline registers (0 = youngest, STAGES-1 = oldest), each
// holding valid, wen, wreg and payload. Per-stage flush, stall with bubble
// insertion above the frozen range, and two forwarding lookups.
// Optional macro PIPE_STAGE_PERF_EN adds bubble_cnt, flush_cnt, retire_cnt.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_wen/in_wreg/in_data   entry offered to stage 0
//   in_ready                          stage 0 loads this cycle (= !stall)
//   stall, stall_at                   freeze stages 0..stall_at
//   flush_mask                        per-stage bubble load
//   src1/src2, fwd*_hit/stage/data    forwarding lookups
//   stage_valid                       valid bit of every stage
//   out_valid/out_wen/out_wreg/out_data, out_fire   oldest stage and its retire strobe

module pipe_stage_chain
   import pipe_pkg::*;
#(
   parameter int STAGES     = 4,
   parameter int DATA_W     = PIPE_DATA_W,
   parameter int REG_ADDR_W = PIPE_REG_ADDR_W,
   parameter int FWD_FIRST  = 1,
   localparam int IDX_W     = stage_idx_w(STAGES)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_wen,
   input  logic [REG_ADDR_W-1:0] in_wreg,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  in_ready,
   input  logic                  stall,
   input  logic [IDX_W-1:0]      stall_at,
   input  logic [STAGES-1:0]     flush_mask,
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   output logic                  fwd1_hit,
   output logic                  fwd2_hit,
   output logic [IDX_W-1:0]      fwd1_stage,
   output logic [IDX_W-1:0]      fwd2_stage,
   output logic [DATA_W-1:0]     fwd1_data,
   output logic [DATA_W-1:0]     fwd2_data,
   output logic [STAGES-1:0]     stage_valid,
   output logic                  out_valid,
   output logic                  out_wen,
   output logic [REG_ADDR_W-1:0] out_wreg,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_fire
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [15:0]           bubble_cnt,
   output logic [15:0]           flush_cnt,
   output logic [15:0]           retire_cnt
`endif
);

   logic [STAGES-1:0]                 valid_q;
   logic [STAGES-1:0]                 wen_q;
   logic [STAGES-1:0][REG_ADDR_W-1:0] wreg_q;
   logic [STAGES-1:0][DATA_W-1:0]     data_q;

   // Value each stage would take if it advanced this cycle.
   logic [STAGES-1:0]                 sh_valid;
   logic [STAGES-1:0]                 sh_wen;
   logic [STAGES-1:0][REG_ADDR_W-1:0] sh_wreg;
   logic [STAGES-1:0][DATA_W-1:0]     sh_data;

   logic [STAGES-1:0] frozen;
   logic [STAGES-1:0] bubble;
   int                stall_at_i;

   always_comb begin
      sh_valid[0] = in_valid;
      sh_wen[0]   = in_wen;
      sh_wreg[0]  = in_wreg;
      sh_data[0]  = in_data;
      for (int k = 1; k < STAGES; k++) begin
         sh_valid[k] = valid_q[k-1];
         sh_wen[k]   = wen_q[k-1];
         sh_wreg[k]  = wreg_q[k-1];
         sh_data[k]  = data_q[k-1];
      end
   end

   // The stage just above the frozen range receives a bubble; when the whole
   // chain is frozen there is no such stage and nothing is inserted.
   always_comb begin
      stall_at_i = int'(stall_at);
      for (int k = 0; k < STAGES; k++) begin
         frozen[k] = stall && (k <= stall_at_i);
         bubble[k] = stall && (k == stall_at_i + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         wen_q   <= '0;
         wreg_q  <= '0;
         data_q  <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (flush_mask[k]) begin
               // Flush wins over freeze: the stage is cleared even when frozen.
               valid_q[k] <= 1'b0;
               wen_q[k]   <= 1'b0;
               wreg_q[k]  <= sh_wreg[k];
               data_q[k]  <= sh_data[k];
            end else if (!frozen[k]) begin
               if (bubble[k]) begin
                  valid_q[k] <= 1'b0;
                  wen_q[k]   <= 1'b0;
               end else begin
                  valid_q[k] <= sh_valid[k];
                  wen_q[k]   <= sh_wen[k];
                  wreg_q[k]  <= sh_wreg[k];
                  data_q[k]  <= sh_data[k];
               end
            end
         end
      end
   end

   assign in_ready    = !stall;
   assign stage_valid = valid_q;
   assign out_valid   = valid_q[STAGES-1];
   assign out_wen     = wen_q[STAGES-1];
   assign out_wreg    = wreg_q[STAGES-1];
   assign out_data    = data_q[STAGES-1];
   assign out_fire    = valid_q[STAGES-1] && !(stall && stall_at_i == STAGES - 1);

   pipe_fwd_lookup #(
      .STAGES     (STAGES),
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_FIRST  (FWD_FIRST)
   ) u_fwd1 (
      .stage_valid (valid_q),
      .stage_wen   (wen_q),
      .stage_wreg  (wreg_q),
      .stage_data  (data_q),
      .src         (src1),
      .hit         (fwd1_hit),
      .hit_stage   (fwd1_stage),
      .hit_data    (fwd1_data)
   );

   pipe_fwd_lookup #(
      .STAGES     (STAGES),
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_FIRST  (FWD_FIRST)
   ) u_fwd2 (
      .stage_valid (valid_q),
      .stage_wen   (wen_q),
      .stage_wreg  (wreg_q),
      .stage_data  (data_q),
      .src         (src2),
      .hit         (fwd2_hit),
      .hit_stage   (fwd2_stage),
      .hit_data    (fwd2_data)
   );

`ifdef PIPE_STAGE_PERF_EN
   // A bubble counts only when it actually lands, i.e. the target stage is
   // not flushed in the same cycle. Flushes count only stages that held a
   // valid entry.
   logic        bubble_evt;
   logic [15:0] flush_inc;

   always_comb begin
      bubble_evt = |(bubble & ~flush_mask);
      flush_inc  = 16'($countones(flush_mask & valid_q));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         bubble_cnt <= sat_add16(bubble_cnt, {15'd0, bubble_evt});
         flush_cnt  <= sat_add16(flush_cnt, flush_inc);
         retire_cnt <= sat_add16(retire_cnt, {15'd0, out_fire});
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - scoreboard testbench for pipe_stage_chain

module tb_pipe_stage_chain;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_wen;
   logic [4:0]  in_wreg;
   logic [63:0] in_data;
   logic        in_ready;
   logic        stall;
   logic [1:0]  stall_at;
   logic [3:0]  flush_mask;
   logic [4:0]  src1, src2;
   logic        fwd1_hit, fwd2_hit;
   logic [1:0]  fwd1_stage, fwd2_stage;
   logic [63:0] fwd1_data, fwd2_data;
   logic [3:0]  stage_valid;
   logic        out_valid, out_wen;
   logic [4:0]  out_wreg;
   logic [63:0] out_data;
   logic        out_fire;
`ifdef PIPE_STAGE_PERF_EN
   logic [15:0] bubble_cnt, flush_cnt, retire_cnt;
`endif

   pipe_stage_chain #(.STAGES(4), .DATA_W(64), .REG_ADDR_W(5), .FWD_FIRST(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_wen(in_wen), .in_wreg(in_wreg), .in_data(in_data),
      .in_ready(in_ready), .stall(stall), .stall_at(stall_at), .flush_mask(flush_mask),
      .src1(src1), .src2(src2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
      .fwd1_stage(fwd1_stage), .fwd2_stage(fwd2_stage),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
      .stage_valid(stage_valid),
      .out_valid(out_valid), .out_wen(out_wen), .out_wreg(out_wreg), .out_data(out_data),
      .out_fire(out_fire)
`ifdef PIPE_STAGE_PERF_EN
      , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   stage_entry_t exp_q[$];
   stage_entry_t mon_e;
   int tests = 0;
   int fails = 0;
   logic [3:0] fill_exp [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [63:0] d, input logic [4:0] w, input logic e);
      stage_entry_t x;
      in_valid = 1'b1;
      in_data  = d;
      in_wreg  = w;
      in_wen   = e;
      if (!stall && !rst) begin
         x.valid = 1'b1;
         x.wen   = e;
         x.wreg  = w;
         x.data  = d;
         exp_q.push_back(x);
      end
   endtask

   // Monitor: every retiring entry must be the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && out_fire) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got data 0x%0h expected none", out_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_data", out_data, mon_e.data);
            chk("sb_wreg", 64'(out_wreg), 64'(mon_e.wreg));
            chk("sb_wen", 64'(out_wen), 64'(mon_e.wen));
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_wreg = '0; in_data = '0;
      stall = 1'b0; stall_at = '0; flush_mask = '0; src1 = '0; src2 = '0;
      nxt();
      nxt();
      src1 = 5'd5; src2 = 5'd3;
      #1;
      chk("rst_stage_valid", 64'(stage_valid), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_out_wreg", 64'(out_wreg), 64'h0);
      chk("rst_fwd1_hit", 64'(fwd1_hit), 64'h0);
      chk("rst_fwd1_data", fwd1_data, 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);
      rst = 1'b0;

      // Stream 0x10..0x15, no stall.
      offer(64'h10, 5'd1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         nxt();
         if (i < 4) chk("fill_stage_valid", 64'(stage_valid), 64'(fill_exp[i]));
         if (i == 2) chk("latency_early", 64'(out_valid), 64'h0);
         if (i == 3) begin
            chk("latency_fire", 64'(out_fire), 64'h1);
            chk("latency_data", out_data, 64'h10);
         end
         if (i < 5) offer(64'h11 + 64'(i), 5'(i + 2), 1'b1);
      end

      // Stall stages 0..1 for two cycles with a full chain.
      in_valid = 1'b0; stall = 1'b1; stall_at = 2'd1;
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'h0);
      nxt();
      chk("stall1_stage_valid", 64'(stage_valid), 64'b1011);
      nxt();
      chk("stall2_stage_valid", 64'(stage_valid), 64'b0011);
      stall = 1'b0;

      // Refill with 0x20..0x23.
      offer(64'h20, 5'd7, 1'b1);
      for (int i = 0; i < 4; i++) begin
         nxt();
         if (i < 3) offer(64'h21 + 64'(i), 5'(8 + i), 1'b1);
      end
      chk("refill_stage_valid", 64'(stage_valid), 64'b1111);

      // Flush stages 0,1 while stalling at 1: 0x22 and 0x23 are dropped.
      in_valid = 1'b0; flush_mask = 4'b0011; stall = 1'b1; stall_at = 2'd1;
      nxt();
      chk("flush_stage_valid", 64'(stage_valid), 64'b1000);
      chk("flush_out_data", out_data, 64'h21);
      chk("flush_q_depth", 64'(exp_q.size()), 64'd3);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      flush_mask = 4'b0000; stall = 1'b0;

      // Forwarding: load BB(r5), 32(r0), AA(r5), 34(r9, wen=0).
      offer(64'hBB, 5'd5, 1'b1); nxt();
      offer(64'h32, 5'd0, 1'b1); nxt();
      offer(64'hAA, 5'd5, 1'b1); nxt();
      offer(64'h34, 5'd9, 1'b0); nxt();
      in_valid = 1'b0; stall = 1'b1; stall_at = 2'd3; src1 = 5'd5; src2 = 5'd0;
      #1;
      chk("freeze_out_fire", 64'(out_fire), 64'h0);
      chk("fwd_stage_valid", 64'(stage_valid), 64'b1111);
      chk("fwd1_hit_young", 64'(fwd1_hit), 64'h1);
      chk("fwd1_stage_young", 64'(fwd1_stage), 64'h1);
      chk("fwd1_data_young", fwd1_data, 64'hAA);
      chk("fwd2_hit_r0", 64'(fwd2_hit), 64'h0);
      chk("fwd2_stage_r0", 64'(fwd2_stage), 64'h0);
      chk("fwd2_data_r0", fwd2_data, 64'h0);

      // Flush stage 1 inside the frozen range; stage 3 becomes the match.
      flush_mask = 4'b0010;
      nxt();
      flush_mask = 4'b0000;
      chk("fwd_q_depth", 64'(exp_q.size()), 64'd4);
      exp_q.delete(2);
      chk("fwdflush_stage_valid", 64'(stage_valid), 64'b1101);
      chk("fwd1_hit_old", 64'(fwd1_hit), 64'h1);
      chk("fwd1_stage_old", 64'(fwd1_stage), 64'h3);
      chk("fwd1_data_old", fwd1_data, 64'hBB);
      stall = 1'b0;
      nxt();
      stall = 1'b1; stall_at = 2'd3; src1 = 5'd0; src2 = 5'd9;
      #1;
      chk("adv_stage_valid", 64'(stage_valid), 64'b1010);
      chk("fwd1_hit_r0_valid", 64'(fwd1_hit), 64'h0);
      chk("fwd2_hit_wen0", 64'(fwd2_hit), 64'h0);
      chk("fwd2_data_wen0", fwd2_data, 64'h0);
      stall = 1'b0;
      repeat (4) nxt();
      chk("drain_q_empty", 64'(exp_q.size()), 64'd0);

      // Reset while stalled mid-stream.
      offer(64'h40, 5'd1, 1'b1); nxt();
      offer(64'h41, 5'd2, 1'b1); nxt();
      in_valid = 1'b0; stall = 1'b1; stall_at = 2'd1; rst = 1'b1;
      nxt();
      exp_q.delete();
      rst = 1'b0;
      chk("midrst_stage_valid", 64'(stage_valid), 64'h0);
      chk("midrst_out_valid", 64'(out_valid), 64'h0);
      chk("midrst_out_data", out_data, 64'h0);
      chk("midrst_in_ready", 64'(in_ready), 64'h0);
`ifdef PIPE_STAGE_PERF_EN
      chk("midrst_bubble_cnt", 64'(bubble_cnt), 64'h0);
      chk("midrst_flush_cnt", 64'(flush_cnt), 64'h0);
      chk("midrst_retire_cnt", 64'(retire_cnt), 64'h0);
`endif
      repeat (300) nxt();
      chk("bubbles_stage_valid", 64'(stage_valid), 64'h0);
`ifdef PIPE_STAGE_PERF_EN
      chk("bubble_cnt_300", 64'(bubble_cnt), 64'd300);
`endif
      stall = 1'b0;
      nxt();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
